// File: rtl/exe_pkg.sv
// Shared encodings and bus-width helpers for the execute stage.
// Width functions keep parameter defaults in one place for every instantiator.
package exe_pkg;

   localparam logic [2:0] MD_NONE = 3'b000;
   localparam logic [2:0] MD_DIV  = 3'b100;
   localparam logic [2:0] MD_MOD  = 3'b101;
   localparam logic [2:0] MD_DIVU = 3'b110;
   localparam logic [2:0] MD_MODU = 3'b111;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // One-hot bit positions inside alu_op
   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_NOR  = 5;
   localparam int ALU_OR   = 6;
   localparam int ALU_XOR  = 7;
   localparam int ALU_SLL  = 8;
   localparam int ALU_SRL  = 9;
   localparam int ALU_SRA  = 10;
   localparam int ALU_LUI  = 11;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   function automatic int id_bus_w(input int xlen);
      return 28 + 4 * xlen;
   endfunction

   function automatic int ex_bus_w(input int xlen);
      return 10 + 2 * xlen;
   endfunction

   // {valid, res_from_mem, ready_go, dest[4:0], result}
   function automatic int fwd_bus_w(input int xlen);
      return 8 + xlen;
   endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, then sign and
// divide-by-zero fix-ups applied combinationally on the held core state.
module div_iter
   import exe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   input  logic            ack,
   input  logic            signed_op,
   input  logic            rem_sel,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] res
);

   localparam int CW = $clog2(XLEN) + 1;

   div_state_t      state;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] dvs;
   logic [CW-1:0]   count;
   logic            neg_q;
   logic            neg_r;
   logic            b_zero;
   logic            rem_sel_r;

   logic            a_neg;
   logic            b_neg;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   trial;
   logic [XLEN-1:0] q_fix;
   logic [XLEN-1:0] r_fix;

   assign a_neg   = signed_op && a[XLEN-1];
   assign b_neg   = signed_op && b[XLEN-1];
   assign shifted = {1'b0, rem, quo[XLEN-1]} >> 0;
   // Top bit of trial is the borrow: set means the divisor did not fit
   assign trial   = shifted - {1'b0, dvs};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= DIV_IDLE;
      end else begin
         case (state)
            DIV_IDLE: if (start) begin
               state     <= DIV_BUSY;
               quo       <= a_neg ? -a : a;
               dvs       <= b_neg ? -b : b;
               rem       <= '0;
               count     <= '0;
               neg_q     <= a_neg ^ b_neg;
               neg_r     <= a_neg;
               b_zero    <= (b == '0);
               rem_sel_r <= rem_sel;
            end
            DIV_BUSY: begin
               rem   <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
               quo   <= {quo[XLEN-2:0], ~trial[XLEN]};
               count <= count + 1'b1;
               if (count == CW'(XLEN - 1)) state <= DIV_DONE;
            end
            DIV_DONE: if (ack) state <= DIV_IDLE;
            default:  state <= DIV_IDLE;
         endcase
      end
   end

   // With a zero divisor the core shifts |a| into rem untouched, so the
   // dividend-sign fix-up hands back a itself; only the quotient needs forcing.
   assign q_fix = b_zero ? '1 : (neg_q ? -quo : quo);
   assign r_fix = neg_r ? -rem : rem;
   assign res   = rem_sel_r ? r_fix : q_fix;
   assign done  = (state == DIV_DONE);

endmodule

// File: rtl/exe_stage_md.sv
// Execute stage: ALU, iterative divide with stall, data-SRAM request
// formatting and the forwarding bus back to decode.
module exe_stage_md
   import exe_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ID_BUS_W = id_bus_w(XLEN),
   parameter int EX_BUS_W = ex_bus_w(XLEN)
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       id_to_ex_valid,
   output logic                       ex_allowin,
   input  logic [ID_BUS_W-1:0]        id_reg,
   input  logic                       mem_allowin,
   output logic                       ex_to_mem_valid,
   output logic [EX_BUS_W-1:0]        ex_reg,
   output logic [fwd_bus_w(XLEN)-1:0] ex_fwd,
   output logic                       data_sram_en,
   output logic [XLEN/8-1:0]          data_sram_we,
   output logic [XLEN-1:0]            data_sram_addr,
   output logic [XLEN-1:0]            data_sram_wdata
);

   localparam int BL = XLEN / 8;
   localparam int SW = $clog2(XLEN);

   logic                ex_valid;
   logic                ex_ready_go;
   logic                handoff;
   logic [ID_BUS_W-1:0] id_reg_r;

   logic [11:0]     alu_op;
   logic [2:0]      md_op;
   logic [1:0]      mem_size;
   logic            mem_unsigned;
   logic            res_from_mem;
   logic            src1_is_pc;
   logic            src2_is_imm;
   logic            gr_we;
   logic            mem_we;
   logic [4:0]      dest;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] rj_value;
   logic [XLEN-1:0] rkd_value;
   logic [XLEN-1:0] pc;

   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic [SW-1:0]   shamt;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] div_res;
   logic            div_done;
   logic [XLEN-1:0] result;
   logic [XLEN-1:0] lane;
   logic [BL-1:0]   st_we;

   assign {alu_op, md_op, mem_size, mem_unsigned, res_from_mem, src1_is_pc,
           src2_is_imm, gr_we, mem_we, dest, imm, rj_value, rkd_value, pc} = id_reg_r;

   always_ff @(posedge clk) begin
      if (!resetn)         ex_valid <= 1'b0;
      else if (ex_allowin) ex_valid <= id_to_ex_valid;
   end

   always_ff @(posedge clk) begin
      if (id_to_ex_valid && ex_allowin) id_reg_r <= id_reg;
   end

   assign src1  = src1_is_pc  ? pc  : rj_value;
   assign src2  = src2_is_imm ? imm : rkd_value;
   assign shamt = src2[SW-1:0];

   always_comb begin
      alu_result = '0;
      if (alu_op[ALU_ADD])  alu_result |= src1 + src2;
      if (alu_op[ALU_SUB])  alu_result |= src1 - src2;
      if (alu_op[ALU_SLT])  alu_result |= {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      if (alu_op[ALU_SLTU]) alu_result |= {{(XLEN-1){1'b0}}, src1 < src2};
      if (alu_op[ALU_AND])  alu_result |= src1 & src2;
      if (alu_op[ALU_NOR])  alu_result |= ~(src1 | src2);
      if (alu_op[ALU_OR])   alu_result |= src1 | src2;
      if (alu_op[ALU_XOR])  alu_result |= src1 ^ src2;
      if (alu_op[ALU_SLL])  alu_result |= src1 << shamt;
      if (alu_op[ALU_SRL])  alu_result |= src1 >> shamt;
      if (alu_op[ALU_SRA])  alu_result |= $unsigned($signed(src1) >>> shamt);
      if (alu_op[ALU_LUI])  alu_result |= src2;
   end

   // Only md_op[2] marks a divide; the remaining codes fall through to the ALU
   div_iter #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .resetn    (resetn),
      .start     (ex_valid && md_op[2]),
      .ack       (handoff),
      .signed_op (!md_op[1]),
      .rem_sel   (md_op[0]),
      .a         (rj_value),
      .b         (rkd_value),
      .done      (div_done),
      .res       (div_res)
   );

   assign ex_ready_go     = md_op[2] ? div_done : 1'b1;
   assign ex_allowin      = !ex_valid || (ex_ready_go && mem_allowin);
   assign ex_to_mem_valid = ex_valid && ex_ready_go;
   assign handoff         = ex_to_mem_valid && mem_allowin;
   assign result          = md_op[2] ? div_res : alu_result;

   assign ex_reg = {res_from_mem, mem_size, mem_unsigned, gr_we, dest, result, pc};
   assign ex_fwd = {ex_valid && gr_we, res_from_mem, ex_ready_go, dest, result};

   assign data_sram_en   = ex_valid && (res_from_mem || mem_we) && mem_allowin;
   assign data_sram_addr = alu_result;

   // Lane math on the low address bits; sub-size alignment bits are dropped
   always_comb begin
      lane            = alu_result & XLEN'(BL - 1);
      st_we           = '0;
      data_sram_wdata = '0;
      for (int i = 0; i < BL; i++) begin
         case (mem_size)
            SZ_B: begin
               st_we[i]                 = (XLEN'(i) == lane);
               data_sram_wdata[8*i +: 8] = rkd_value[7:0];
            end
            SZ_H: begin
               st_we[i]                 = (XLEN'(i / 2) == (lane >> 1));
               data_sram_wdata[8*i +: 8] = rkd_value[8*(i%2) +: 8];
            end
            default: begin
               st_we[i]                 = 1'b1;
               data_sram_wdata[8*i +: 8] = rkd_value[8*i +: 8];
            end
         endcase
      end
   end

   assign data_sram_we = (data_sram_en && mem_we) ? st_we : '0;

endmodule

// File: tb/tb_exe_stage_md.sv
// Randomised bench for exe_stage_md with a queue-based reference model.
module tb_exe_stage_md;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          id_to_ex_valid = 1'b0;
   logic          ex_allowin;
   logic [155:0]  id_reg = '0;
   logic          mem_allowin = 1'b1;
   logic          ex_to_mem_valid;
   logic [73:0]   ex_reg;
   logic [39:0]   ex_fwd;
   logic          data_sram_en;
   logic [3:0]    data_sram_we;
   logic [31:0]   data_sram_addr;
   logic [31:0]   data_sram_wdata;

   exe_stage_md #(.XLEN(32)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .id_to_ex_valid  (id_to_ex_valid),
      .ex_allowin      (ex_allowin),
      .id_reg          (id_reg),
      .mem_allowin     (mem_allowin),
      .ex_to_mem_valid (ex_to_mem_valid),
      .ex_reg          (ex_reg),
      .ex_fwd          (ex_fwd),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] alu_op;
      logic [2:0]  md;
      logic [1:0]  sz;
      logic        uns, rfm, s1pc, s2imm, gwe, mwe;
      logic [4:0]  dest;
      logic [31:0] imm, rj, rkd, pc;
      int          enter;
      logic [31:0] exp_res;
   } ins_t;

   ins_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   ma_force = 1;   // 1 high, 0 low, -1 random
   bit   chk_en = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      mem_allowin = (ma_force == 1) ? 1'b1 : (ma_force == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] alu_model(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
      int idx = -1;
      for (int n = 0; n < 12; n++) if (op[n]) idx = n;
      case (idx)
         0:  return a + b;
         1:  return a - b;
         2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3:  return (a < b) ? 32'd1 : 32'd0;
         4:  return a & b;
         5:  return ~(a | b);
         6:  return a | b;
         7:  return a ^ b;
         8:  return a << b[4:0];
         9:  return a >> b[4:0];
         10: return 32'($signed(a) >>> b[4:0]);
         11: return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] div_model(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b);
      int sa = a;
      int sb = b;
      if (b == 0) return md[0] ? a : 32'hFFFF_FFFF;
      if (!md[1]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return md[0] ? 32'd0 : 32'h8000_0000;
         return md[0] ? 32'(sa % sb) : 32'(sa / sb);
      end
      return md[0] ? a % b : a / b;
   endfunction

   function automatic logic [31:0] model_res(input ins_t i);
      if (i.md[2]) return div_model(i.md, i.rj, i.rkd);
      return alu_model(i.alu_op, i.s1pc ? i.pc : i.rj, i.s2imm ? i.imm : i.rkd);
   endfunction

   function automatic logic [35:0] st_model(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] d);
      case (sz)
         2'd0:    return {4'b0001 << addr[1:0], {4{d[7:0]}}};
         2'd1:    return {addr[1] ? 4'b1100 : 4'b0011, {2{d[15:0]}}};
         default: return {4'b1111, d};
      endcase
   endfunction

   function automatic logic [155:0] pack(input ins_t i);
      return {i.alu_op, i.md, i.sz, i.uns, i.rfm, i.s1pc, i.s2imm, i.gwe, i.mwe,
              i.dest, i.imm, i.rj, i.rkd, i.pc};
   endfunction

   function automatic ins_t base();
      ins_t i;
      i.alu_op = 12'h001; i.md = 3'b000; i.sz = 2'd2;
      i.uns = 0; i.rfm = 0; i.s1pc = 0; i.s2imm = 0; i.gwe = 1; i.mwe = 0;
      i.dest = 5'd1; i.imm = 0; i.rj = 0; i.rkd = 0; i.pc = 32'h1c00_0000;
      i.enter = 0; i.exp_res = 0;
      return i;
   endfunction

   function automatic logic [31:0] rnd();
      return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 16)) : 32'($urandom);
   endfunction

   function automatic ins_t gen();
      ins_t i = base();
      int k = $urandom_range(0, 99);
      i.rj = rnd(); i.rkd = rnd(); i.imm = rnd(); i.pc = $urandom;
      i.dest = 5'($urandom); i.gwe = 1'($urandom);
      if (k < 15) begin
         i.md = {1'b1, 2'($urandom)};
         i.alu_op = 12'(1) << $urandom_range(0, 11);
         case ($urandom_range(0, 5))
            0: i.rkd = 0;
            1: begin i.rj = 32'h8000_0000; i.rkd = 32'hFFFF_FFFF; end
            2: i.rkd = 32'($urandom_range(0, 9)) - 32'd4;
            default: ;
         endcase
      end else if (k < 40) begin
         i.s2imm = 1; i.imm = 32'($urandom_range(0, 255));
         i.rj = 32'h2000 + 32'($urandom_range(0, 4095));
         i.sz = 2'($urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1) begin i.mwe = 1; i.gwe = 0; end
         else begin i.rfm = 1; i.gwe = 1; i.uns = 1'($urandom); end
      end else begin
         i.alu_op = 12'(1) << $urandom_range(0, 11);
         i.md = 3'($urandom_range(0, 3));
         i.s1pc = 1'($urandom); i.s2imm = 1'($urandom);
      end
      return i;
   endfunction

   task automatic issue(input ins_t in);
      int guard = 0;
      @(negedge clk);
      id_reg = pack(in);
      id_to_ex_valid = 1'b1;
      #1;
      while (!ex_allowin && guard < 300) begin
         @(negedge clk); #1; guard++;
      end
      if (!ex_allowin) begin
         total++; bad++;
         $display("FAIL issue_timeout: allowin=0 want 1");
         id_to_ex_valid = 1'b0;
         return;
      end
      in.enter = cyc + 1;
      in.exp_res = model_res(in);
      q.push_back(in);
      @(posedge clk); #1;
      id_to_ex_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (q.size() != 0 && guard < 300) begin @(posedge clk); guard++; end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: left=%0d want 0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   // Per-cycle comparison against the queue model
   always @(negedge clk) begin
      #2;
      if (chk_en) begin
         ins_t h;
         bit in_ex, rdy, memop;
         in_ex = 0;
         if (q.size() > 0) begin h = q[0]; in_ex = (h.enter <= cyc); end
         rdy   = in_ex && (!h.md[2] || (cyc - h.enter >= 33));
         memop = in_ex && (h.rfm || h.mwe);
         check("to_mem_valid", ex_to_mem_valid, rdy);
         check("allowin", ex_allowin, !in_ex || (rdy && mem_allowin));
         check("sram_en", data_sram_en, memop && mem_allowin);
         check("fwd_valid", ex_fwd[39], in_ex && h.gwe);
         if (!(memop && mem_allowin && h.mwe)) check("sram_we_idle", data_sram_we, 4'b0);
         if (rdy) begin
            check("ex_reg", ex_reg, {h.rfm, h.sz, h.uns, h.gwe, h.dest, h.exp_res, h.pc});
            check("ex_fwd", ex_fwd[38:0], {h.rfm, 1'b1, h.dest, h.exp_res});
            if (memop && mem_allowin) begin
               logic [35:0] s;
               s = st_model(h.exp_res, h.sz, h.rkd);
               check("sram_addr", data_sram_addr, h.exp_res);
               if (h.mwe) begin
                  check("sram_we", data_sram_we, s[35:32]);
                  check("sram_wdata", data_sram_wdata, s[31:0]);
               end
            end
            if (mem_allowin) void'(q.pop_front());
         end
      end
   end

   task automatic do_reset(input int n);
      resetn = 1'b0; chk_en = 0; id_to_ex_valid = 1'b0;
      q.delete();
      repeat (n) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1; chk_en = 1;
   endtask

   initial begin
      ins_t i;
      do_reset(3);

      // add.w 5+7
      i = base(); i.rj = 5; i.rkd = 7;
      check("pin_add", model_res(i), 32'd12);
      issue(i);
      drain();

      // divide family, issued back-to-back
      i = base(); i.md = 3'b100; i.rj = 32'hFFFF_FFF9; i.rkd = 2;
      check("pin_div_w", model_res(i), 32'hFFFF_FFFD); issue(i);
      i.md = 3'b101;
      check("pin_mod_w", model_res(i), 32'hFFFF_FFFF); issue(i);
      i.md = 3'b110; i.rj = 32'h8000_0000; i.rkd = 0;
      check("pin_divu_0", model_res(i), 32'hFFFF_FFFF); issue(i);
      i.md = 3'b111;
      check("pin_modu_0", model_res(i), 32'h8000_0000); issue(i);
      i.md = 3'b100; i.rkd = 32'hFFFF_FFFF;
      check("pin_div_ovf", model_res(i), 32'h8000_0000); issue(i);
      drain();

      // st.b / st.h / ld.w
      i = base(); i.s2imm = 1; i.rj = 32'h1000; i.imm = 3; i.rkd = 32'h1234_5678;
      i.mwe = 1; i.gwe = 0; i.sz = 2'd0;
      check("pin_stb", st_model(32'h1003, 2'd0, i.rkd), {4'b1000, 32'h7878_7878});
      issue(i);
      i.imm = 2; i.sz = 2'd1;
      check("pin_sth", st_model(32'h1002, 2'd1, i.rkd), {4'b1100, 32'h5678_5678});
      issue(i);
      i.mwe = 0; i.rfm = 1; i.gwe = 1; i.sz = 2'd2; i.imm = 8;
      issue(i);
      drain();

      // DONE held under 5 cycles of backpressure
      @(posedge clk); ma_force = 0;
      i = base(); i.md = 3'b110; i.rj = 32'd1000; i.rkd = 32'd7;
      issue(i);
      repeat (33 + 5) @(negedge clk);
      @(posedge clk); ma_force = 1;
      drain();

      // reset during BUSY cycle 10, then a fresh add
      i = base(); i.md = 3'b100; i.rj = 32'd99; i.rkd = 32'd5;
      issue(i);
      repeat (11) @(negedge clk);
      do_reset(1);
      @(negedge clk);
      i = base(); i.rj = 32'd40; i.rkd = 32'd2;
      issue(i);
      drain();

      // randomised traffic with random backpressure
      @(posedge clk); ma_force = -1;
      for (int n = 0; n < 300; n++) issue(gen());
      @(posedge clk); ma_force = 1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
